// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer
//   Control-word sequencer for the 8-bit adder/accumulator datapath.
//   It accepts 4-bit opcodes over a valid/ready handshake. Each accepted
//   opcode runs IDLE -> EXEC (1 cycle) -> WAIT (WAIT_CYCLES cycles) and
//   then retires back to IDLE. HLT retires into HALT instead.
//   It latches CF/ZF after ADD/SUB and uses them for SKZ/SKC skips.
//
// Build option:
//   SEQ_RETIRE_CNT_EN  defined: the retired-instruction counter is built.
//                      undefined: no counter flops; retired_cnt reads 0.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   instr/instr_valid     opcode offered by the upstream
//   instr_ready           high only in IDLE
//   resume                1-cycle pulse that leaves HALT
//   cf_in, zf_in          datapath flags, sampled on the last WAIT cycle
//   nla nlb ea eu sub     datapath control word (registered)
//   bus_sel               output mux select (registered)
//   busy, halted          status decoded from the registered state
//   illegal               sticky flag for an executed undefined opcode
//   cf_q, zf_q            latched flags
//   retired_cnt           count of retired opcodes; wraps
module sap_control_sequencer #(
  parameter int CNT_W       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             resume,
  input  logic             cf_in,
  input  logic             zf_in,
  output logic             nla,
  output logic             nlb,
  output logic             ea,
  output logic             eu,
  output logic             sub,
  output logic             bus_sel,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             cf_q,
  output logic             zf_q,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_HALT} state_t;

  // Control word packing: {nla, nlb, ea, eu, sub, bus_sel}
  localparam logic [5:0] CW_IDLE   = 6'b110000;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_SKZ = 4'h6;
  localparam logic [3:0] OP_SKC = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state;
  logic [3:0] ir;
  logic [2:0] wait_cnt;
  logic       skip_pending;
  logic [5:0] cw;
  logic       retire;

  function automatic logic [5:0] decode(input logic [3:0] op);
    case (op)
      OP_LDA:  decode = 6'b010000;
      OP_LDB:  decode = 6'b100000;
      OP_ADD:  decode = 6'b010100;
      OP_SUB:  decode = 6'b010110;
      OP_OUT:  decode = 6'b111001;
      default: decode = CW_IDLE;
    endcase
  endfunction

  assign {nla, nlb, ea, eu, sub, bus_sel} = cw;
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign halted      = (state == S_HALT);
  assign retire      = (state == S_WAIT) && (wait_cnt == WAIT_LAST);

  // The control word is loaded on the edge that enters EXEC.
  // This keeps every output a flop, so instr never reaches the pins
  // combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ir           <= 4'h0;
      wait_cnt     <= 3'd0;
      skip_pending <= 1'b0;
      cw           <= CW_IDLE;
      illegal      <= 1'b0;
      cf_q         <= 1'b0;
      zf_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            if (skip_pending) begin
              // The opcode is consumed but discarded, and it does not retire.
              skip_pending <= 1'b0;
            end else begin
              ir    <= instr;
              cw    <= decode(instr);
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          cw       <= CW_IDLE;
          wait_cnt <= 3'd0;
          state    <= S_WAIT;
          if (ir == OP_SKZ && zf_q) skip_pending <= 1'b1;
          if (ir == OP_SKC && cf_q) skip_pending <= 1'b1;
          if (ir[3] && ir != OP_HLT) illegal <= 1'b1;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            if (ir == OP_ADD || ir == OP_SUB) begin
              cf_q <= cf_in;
              zf_q <= zf_in;
            end
            state <= (ir == OP_HLT) ? S_HALT : S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_HALT: begin
          if (resume) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + 1'b1;
  end
`else
  assign retired_cnt = '0;
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_sap_control_sequencer.sv
module tb_sap_control_sequencer;
  localparam int CNT_W = 4;
  localparam int W     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] instr = 4'h0;
  logic instr_valid = 1'b0, resume = 1'b0, cf_in = 1'b0, zf_in = 1'b0;
  logic instr_ready, nla, nlb, ea, eu, sub, bus_sel, busy, halted, illegal, cf_q, zf_q;
  logic [CNT_W-1:0] retired_cnt;

  sap_control_sequencer #(.CNT_W(CNT_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .resume(resume), .cf_in(cf_in), .zf_in(zf_in),
    .nla(nla), .nlb(nlb), .ea(ea), .eu(eu), .sub(sub), .bus_sel(bus_sel),
    .busy(busy), .halted(halted), .illegal(illegal), .cf_q(cf_q), .zf_q(zf_q),
    .retired_cnt(retired_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ctl;
    logic cf, zf, ill, hlt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit mon_en = 0;
  bit have = 0;
  logic [5:0] ctl;
  assign ctl = {nla, nlb, ea, eu, sub, bus_sel};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control word expected during EXEC: {nla, nlb, ea, eu, sub, bus_sel}
  function automatic logic [5:0] ctl_of(input logic [3:0] op);
    case (op)
      4'h1: return 6'b010000;
      4'h2: return 6'b100000;
      4'h3: return 6'b010100;
      4'h4: return 6'b010110;
      4'h5: return 6'b111001;
      default: return 6'b110000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] cnt_view(input logic [CNT_W-1:0] c);
`ifdef SEQ_RETIRE_CNT_EN
    return c;
`else
    return (c & '0);
`endif
  endfunction

  // Monitor: an EXEC cycle is the first busy cycle after a non-busy one.
  initial begin : monitor
    exp_t cur;
    bit pb;
    pb = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy && !pb) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL exec_unexpected: got exec ctl %b, required no exec", ctl);
          end else begin
            cur = q.pop_front();
            have = 1;
            chk("exec_ctl", 32'(ctl), 32'(cur.ctl));
          end
        end else begin
          chk("idle_ctl", 32'(ctl), 32'(6'b110000));
          if (have && (!busy || halted)) begin
            chk("cf_q", 32'(cf_q), 32'(cur.cf));
            chk("zf_q", 32'(zf_q), 32'(cur.zf));
            chk("illegal", 32'(illegal), 32'(cur.ill));
            chk("halted", 32'(halted), 32'(cur.hlt));
            chk("retired_cnt", 32'(retired_cnt), 32'(cnt_view(cur.cnt)));
            have = 0;
          end
        end
      end
      pb = busy;
    end
  end

  // Reference model state (transaction level)
  bit m_skip, m_cf, m_zf, m_ill, m_halt;
  logic [CNT_W-1:0] m_cnt;
  int cyc, ready_at, halt_at;

  initial begin : driver
    bit exp_rdy, v;
    logic [3:0] op;
    exp_t e;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'(ctl), 32'(6'b110000));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_flags", 32'({cf_q, zf_q}), 0);
    chk("rst_cnt", 32'(retired_cnt), 0);
    chk("rst_ready", 32'(instr_ready), 1);
    // Full ADD sets both flags
    rst_n = 1; instr = 4'h3; instr_valid = 1; cf_in = 1; zf_in = 1;
    @(negedge clk); instr_valid = 0;
    chk("dir_add_ctl", 32'(ctl), 32'(6'b010100));
    repeat (W + 1) @(negedge clk);
    chk("dir_add_flags", 32'({cf_q, zf_q}), 32'(2'b11));
    chk("dir_add_cnt", 32'(retired_cnt), 32'(cnt_view(4'd1)));
    chk("dir_add_busy", 32'(busy), 0);
    // A second ADD is reset mid-EXEC
    instr_valid = 1; cf_in = 0; zf_in = 0;
    @(negedge clk); instr_valid = 0;
    chk("dir_exec_eu", 32'(eu), 1);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_ctl", 32'(ctl), 32'(6'b110000));
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_flags", 32'({cf_q, zf_q}), 0);
    chk("midrst_cnt", 32'(retired_cnt), 0);
    rst_n = 1;
    // Random phase
    m_skip = 0; m_cf = 0; m_zf = 0; m_ill = 0; m_halt = 0; m_cnt = '0;
    cyc = 0; ready_at = 0; halt_at = 0;
    mon_en = 1;
    for (int k = 0; k < 4000; k++) begin
      exp_rdy = !m_halt && (cyc >= ready_at);
      chk("instr_ready", 32'(instr_ready), 32'(exp_rdy));
      resume = ($urandom_range(7) == 0);
      if (resume && m_halt && cyc >= halt_at) begin
        m_halt = 0;
        ready_at = cyc + 1;
      end
      v = ($urandom_range(3) != 0);
      op = 4'($urandom_range(15));
      instr = op;
      instr_valid = v;
      if (v && exp_rdy) begin
        cf_in = 1'($urandom);
        zf_in = 1'($urandom);
        if (m_skip) begin
          m_skip = 0;
          ready_at = cyc + 1;
        end else begin
          if (op == 4'h6 && m_zf) m_skip = 1;
          if (op == 4'h7 && m_cf) m_skip = 1;
          if (op == 4'h3 || op == 4'h4) begin m_cf = cf_in; m_zf = zf_in; end
          if (op >= 4'h8 && op <= 4'hE) m_ill = 1;
          m_cnt = m_cnt + 1'b1;
          if (op == 4'hF) begin
            m_halt = 1;
            halt_at = cyc + 2 + W;
          end else begin
            ready_at = cyc + 2 + W;
          end
          e.ctl = ctl_of(op); e.cf = m_cf; e.zf = m_zf; e.ill = m_ill;
          e.hlt = (op == 4'hF); e.cnt = m_cnt;
          q.push_back(e);
        end
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 0; resume = 0;
    repeat (2 * (W + 3)) @(negedge clk);
    chk("drain_queue", 32'(q.size()), 0);
    chk("drain_pending", 32'(have), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
